fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbitration logic.
package fifo_pkg;

  // Default FIFO data width; matches the FIFO buf_in port.
  localparam int FIFO_DATA_W = 8;

  // Arbiter states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Ceiling log2 for sizing index fields. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: picks the first set request bit scanning upward
// from rr_ptr and wrapping modulo NUM_REQ. Purely combinational.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  // Scan from the farthest offset down so the closest set bit to rr_ptr wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant lasts at most MAX_BURST accepted beats; a full FIFO stalls the
// burst without losing the grant.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no owner; pick next winner from rr_ptr, no ack issued
//   ST_BURST | grant_id owns the write port; ack beats while not full
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      buf_full,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         buf_in,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam logic [7:0]      MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic               burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_id),
    .found  (pick_found)
  );

  // Next-state, grant bookkeeping and the combinational write-port drive.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    ack        = '0;
    wr_en      = 1'b0;
    buf_in     = '0;
    burst_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d    = NUM_REQ'(1) << pick_id;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        ack   = grant_q & req & {NUM_REQ{~buf_full}};
        wr_en = |ack;
        if (wr_en) begin
          buf_in     = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        // A withdrawn request ends the burst even while the FIFO is full.
        burst_end = (wr_en && (beat_cnt_q + 8'd1 == MAX_BURST_C)) || !req[grant_id_q];
        if (burst_end) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q == ST_BURST);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural owner/beat-count model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           buf_full = 1'b0;
  logic           wr_en;
  logic [W-1:0]   buf_in;
  logic           busy;
  logic [1:0]     grant_id;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .MAX_BURST (MB),
    .ID_W      (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .buf_full (buf_full),
    .wr_en    (wr_en),
    .buf_in   (buf_in),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model: owner = -1 when nobody holds the port.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;

  logic [W-1:0] dat [N];
  bit           inc_mode = 1'b0;

  logic         last_wr;
  logic [W-1:0] last_buf;
  logic         last_busy;
  logic [1:0]   last_gid;
  logic [N-1:0] last_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs on the falling edge, check outputs 1ns later,
  // then advance the model to what the next rising edge should produce.
  task automatic tick(input logic [N-1:0] r, input logic f, input logic rs);
    logic [N-1:0] e_ack;
    logic         acc;
    @(negedge clk);
    req      = r;
    buf_full = f;
    rst      = rs;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    #1;
    e_ack = '0;
    if (m_owner >= 0 && r[m_owner] && !f) e_ack[m_owner] = 1'b1;
    acc = (e_ack != '0);
    chk("ack", 32'(ack), 32'(e_ack));
    chk("wr_en", 32'(wr_en), 32'(acc));
    chk("buf_in", 32'(buf_in), acc ? 32'(dat[m_owner]) : 32'h0);
    chk("busy", 32'(busy), (m_owner >= 0) ? 32'h1 : 32'h0);
    if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
    last_wr   = wr_en;
    last_buf  = buf_in;
    last_busy = busy;
    last_gid  = grant_id;
    last_ack  = ack;

    if (acc) dat[m_owner] = inc_mode ? dat[m_owner] + 8'd1 : 8'($urandom);

    if (rs) begin
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_beats = 0;
        end
      end
    end else begin
      if (acc) m_beats++;
      if ((acc && m_beats == MB) || !r[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    logic [9:0]   wp;
    logic [W-1:0] wq[$];
    int           gq[$];
    int           n1;
    logic         prev_busy;
    logic [N-1:0] rr;
    logic         ff, rs;

    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);

    // Reset, then idle with no requests.
    tick('0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick('0, 1'b0, 1'b0);
      chk("idle_gid", 32'(last_gid), 32'h0);
    end

    // Single requester: bursts of MB with one bubble.
    inc_mode = 1'b1;
    dat[0]   = 8'h10;
    wp       = '0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001, 1'b0, 1'b0);
      wp = {wp[8:0], last_wr};
      if (last_wr) wq.push_back(last_buf);
    end
    chk("wr_pattern", 32'(wp), 32'(10'b0111101111));
    chk("wr_count", 32'(wq.size()), 32'd8);
    for (int i = 0; i < wq.size(); i++) chk("wr_data", 32'(wq[i]), 32'h10 + 32'(i));
    inc_mode = 1'b0;

    // All requesters held from reset: grant order 0,1,2,3,0.
    tick(4'b1111, 1'b0, 1'b1);
    prev_busy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick(4'b1111, 1'b0, 1'b0);
      if (last_busy && !prev_busy) gq.push_back(int'(last_gid));
      prev_busy = last_busy;
    end
    chk("rr_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < gq.size() && i < 5; i++) chk("rr_order", 32'(gq[i]), 32'(i % N));

    // Full stall mid-burst of requester 1.
    tick(4'b0110, 1'b0, 1'b1);
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0110, (i >= 3 && i <= 5), 1'b0);
      if (last_ack[1]) n1++;
      if (i >= 3 && i <= 5) chk("stall_wr", 32'(last_wr), 32'h0);
      if (i == 9) begin
        chk("stall_next_busy", 32'(last_busy), 32'h1);
        chk("stall_next_gid", 32'(last_gid), 32'h2);
      end
    end
    chk("stall_beats", 32'(n1), 32'd4);

    // Requester 2 withdraws after two beats; next grant goes to 3.
    tick(4'b1100, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick((i < 3) ? 4'b1100 : 4'b1000, 1'b0, 1'b0);
      if (i == 3) chk("drop_ack", 32'(last_ack), 32'h0);
      if (i == 4) chk("drop_bubble", 32'(last_busy), 32'h0);
      if (i == 5) chk("drop_next_gid", 32'(last_gid), 32'h3);
    end

    // Reset pulsed mid-burst of requester 3.
    tick(4'b1000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(4'b1000, 1'b0, (i == 2));
      if (i == 2) chk("rst_beat_written", 32'(last_wr), 32'h1);
      if (i == 3) chk("rst_idle", 32'(last_busy), 32'h0);
      if (i == 4) begin
        chk("rst_regrant_busy", 32'(last_busy), 32'h1);
        chk("rst_regrant_gid", 32'(last_gid), 32'h3);
      end
    end

    // Random traffic against the model.
    rr = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
      ff = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 99) == 0);
      tick(rr, ff, rs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
